// File: rtl/turbo_interleave_sequencer_if.sv
// Frame handshakes of the turbo interleave sequencer:
// upstream frame in, systematic/interleaved pair out.
interface turbo_interleave_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sys;
  logic [7:0] out_int;

  modport master (
    output in_valid,
    input  in_ready,
    output in_data,
    input  out_valid,
    output out_ready,
    input  out_sys,
    input  out_int
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_data,
    output out_valid,
    input  out_ready,
    output out_sys,
    output out_int
  );
endinterface

// File: rtl/turbo_interleave_sequencer.sv
// Frame sequencer in front of the LFSR interleaver: drives the frame,
// waits for done, then presents systematic+interleaved pair downstream.
module turbo_interleave_sequencer #(
  parameter int SETTLE_CYC  = 2,
  parameter int TIMEOUT_CYC = 32,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  turbo_interleave_sequencer_if.slave bus,
  output logic [7:0]            il_seq_in,
  input  logic [7:0]            il_seq_out,
  input  logic                  il_enable,
  output logic                  busy,
  output logic                  timeout_err,
  input  logic                  err_clr,
  output logic [CNT_W-1:0]      frame_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYC);

  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] S_LAST = TW'(SETTLE_CYC - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  logic [1:0]    state;
  logic [TW-1:0] tcnt;
  logic          cache_valid;
  logic [7:0]    sys_q;
  logic [7:0]    int_q;
  logic          hit;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == HOLD);
  assign bus.out_sys   = sys_q;
  assign bus.out_int   = int_q;
  assign busy          = (state != IDLE);

  // Interleaver does not restart on an identical frame; reuse its result.
  assign hit = cache_valid && (bus.in_data == il_seq_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tcnt        <= '0;
      cache_valid <= 1'b0;
      sys_q       <= '0;
      int_q       <= '0;
      il_seq_in   <= '0;
      timeout_err <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      if (err_clr)
        timeout_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sys_q <= bus.in_data;
            if (hit) begin
              state <= HOLD;
            end else begin
              il_seq_in   <= bus.in_data;
              cache_valid <= 1'b0;
              tcnt        <= '0;
              state       <= LOAD;
            end
          end
        end
        LOAD: begin
          if (tcnt == T_LAST) begin
            timeout_err <= 1'b1;
            cache_valid <= 1'b0;
            state       <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
            if (tcnt == S_LAST)
              state <= WAIT;
          end
        end
        WAIT: begin
          // Capture has priority over a coincident timeout.
          if (il_enable) begin
            int_q       <= il_seq_out;
            cache_valid <= 1'b1;
            state       <= HOLD;
          end else if (tcnt == T_LAST) begin
            timeout_err <= 1'b1;
            cache_valid <= 1'b0;
            state       <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            frame_cnt <= frame_cnt + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_turbo_interleave_sequencer.sv
// Self-checking bench for turbo_interleave_sequencer with a
// behavioural interleaver model (bit reverse, 16-cycle busy).
module tb_turbo_interleave_sequencer;

  localparam int SETTLE  = 2;
  localparam int TMO     = 32;
  localparam int CW      = 16;
  localparam int LMAX    = 100;
  // Edges from accept to out_valid: done falls 1 edge after the new
  // frame, rises 16 edges later, captured on the following edge.
  localparam int L_FULL  = 1 + 16 + 1;
  localparam int L_STALE = SETTLE + 1;
  localparam int L_HIT   = 0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    il_seq_in;
  logic [7:0]    il_seq_out;
  logic          il_enable;
  logic          busy;
  logic          timeout_err;
  logic          err_clr = 1'b0;
  logic [CW-1:0] frame_cnt;

  int tests_run = 0;
  int tests_failed = 0;
  int exp_cnt = 0;

  turbo_interleave_sequencer_if bus ();

  turbo_interleave_sequencer #(
    .SETTLE_CYC (SETTLE),
    .TIMEOUT_CYC(TMO),
    .CNT_W      (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .il_seq_in  (il_seq_in),
    .il_seq_out (il_seq_out),
    .il_enable  (il_enable),
    .busy       (busy),
    .timeout_err(timeout_err),
    .err_clr    (err_clr),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // Interleaver model
  logic [7:0] m_prev = 8'h00;
  int         m_cnt = 16;
  logic       stuck = 1'b0;

  always @(posedge clk) begin
    m_prev <= il_seq_in;
    if (il_seq_in != m_prev) m_cnt <= 0;
    else if (m_cnt < 16) m_cnt <= m_cnt + 1;
  end

  assign il_enable  = !stuck && (m_cnt >= 16);
  assign il_seq_out = rev8(il_seq_in);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_accept(input logic [7:0] d);
    int g;
    g = 0;
    while (!bus.in_ready && g < LMAX) begin
      step();
      g++;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic accept_wait(input logic [7:0] d, output int lat);
    drive_accept(d);
    lat = 0;
    while (!bus.out_valid && lat < LMAX) begin
      step();
      lat++;
    end
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    exp_cnt++;
  endtask

  task automatic test_reset();
    step();
    step();
    tests_run++;
    if ({bus.out_valid, bus.out_sys, bus.out_int, il_seq_in,
         busy, timeout_err, frame_cnt} !== '0 || bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset: ov=%b sys=%h int=%h seq=%h busy=%b err=%b cnt=%0d rdy=%b want all 0, rdy=1",
               bus.out_valid, bus.out_sys, bus.out_int, il_seq_in,
               busy, timeout_err, frame_cnt, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int lat;
    accept_wait(8'hA5, lat);
    tests_run++;
    if (lat !== L_FULL || bus.out_sys !== 8'hA5 || bus.out_int !== 8'hA5) begin
      tests_failed++;
      $display("FAIL basic: lat=%0d sys=%h int=%h want lat=%0d sys=a5 int=a5",
               lat, bus.out_sys, bus.out_int, L_FULL);
    end
    handshake();
    tests_run++;
    if (frame_cnt !== CW'(exp_cnt) || bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_cnt: cnt=%0d ov=%b want %0d ov=0",
               frame_cnt, bus.out_valid, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    accept_wait(8'h3C, lat);
    tests_run++;
    if (lat !== L_FULL || bus.out_int !== 8'h3C) begin
      tests_failed++;
      $display("FAIL b2b_first: lat=%0d int=%h want %0d 3c",
               lat, bus.out_int, L_FULL);
    end
    handshake();
    accept_wait(8'h3C, lat);
    tests_run++;
    if (lat !== L_HIT || bus.out_int !== 8'h3C ||
        bus.out_sys !== 8'h3C || il_seq_in !== 8'h3C) begin
      tests_failed++;
      $display("FAIL b2b_hit: lat=%0d sys=%h int=%h seq=%h want %0d 3c 3c 3c",
               lat, bus.out_sys, bus.out_int, il_seq_in, L_HIT);
    end
    handshake();
    tests_run++;
    if (frame_cnt !== CW'(exp_cnt)) begin
      tests_failed++;
      $display("FAIL b2b_cnt: cnt=%0d want %0d", frame_cnt, exp_cnt);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    accept_wait(8'h01, lat);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid !== 1'b1 || bus.out_sys !== 8'h01 ||
          bus.out_int !== 8'h80 || bus.in_ready !== 1'b0) bad++;
      step();
    end
    tests_run++;
    if (lat !== L_FULL || bad !== 0) begin
      tests_failed++;
      $display("FAIL backpressure: lat=%0d bad_cycles=%0d want %0d 0",
               lat, bad, L_FULL);
    end
    handshake();
    tests_run++;
    if (frame_cnt !== CW'(exp_cnt) || bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_release: cnt=%0d ov=%b want %0d 0",
               frame_cnt, bus.out_valid, exp_cnt);
    end
  endtask

  task automatic test_timeout();
    int lat;
    int seen;
    stuck = 1'b1;
    drive_accept(8'hF0);
    seen = 0;
    for (int i = 1; i < TMO; i++) begin
      if (bus.out_valid) seen++;
      step();
    end
    tests_run++;
    if (timeout_err !== 1'b0 || busy !== 1'b1 || seen !== 0) begin
      tests_failed++;
      $display("FAIL tmo_early: err=%b busy=%b ov_seen=%0d want 0 1 0",
               timeout_err, busy, seen);
    end
    step();
    tests_run++;
    if (timeout_err !== 1'b1 || busy !== 1'b0 ||
        bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL tmo_fire: err=%b busy=%b rdy=%b ov=%b want 1 0 1 0",
               timeout_err, busy, bus.in_ready, bus.out_valid);
    end
    stuck = 1'b0;
    accept_wait(8'hF0, lat);
    tests_run++;
    if (lat !== L_STALE || bus.out_int !== 8'h0F || bus.out_sys !== 8'hF0) begin
      tests_failed++;
      $display("FAIL tmo_resend: lat=%0d sys=%h int=%h want %0d f0 0f",
               lat, bus.out_sys, bus.out_int, L_STALE);
    end
    handshake();
  endtask

  task automatic test_err_clr_race();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    tests_run++;
    if (timeout_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_clr_plain: err=%b want 0", timeout_err);
    end
    stuck = 1'b1;
    drive_accept(8'h77);
    for (int i = 1; i < TMO; i++) step();
    err_clr = 1'b1;
    step();
    tests_run++;
    if (timeout_err !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_race: err=%b busy=%b want 1 0", timeout_err, busy);
    end
    step();
    err_clr = 1'b0;
    tests_run++;
    if (timeout_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_clr_after: err=%b want 0", timeout_err);
    end
    stuck = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] seq;
    logic       cache;
    logic [7:0] d;
    int lat;
    int want;
    int hold;
    int bad;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    seq = 8'h00;
    cache = 1'b0;
    for (int i = 0; i < 20; i++) step();
    for (int n = 0; n < 40; n++) begin
      d = 8'($urandom_range(0, 3)) << 6 | 8'($urandom_range(0, 1));
      if (cache && d == seq) want = L_HIT;
      else if (d != seq) want = L_FULL;
      else want = L_STALE;
      accept_wait(d, lat);
      hold = $urandom_range(0, 3);
      bad = 0;
      for (int h = 0; h < hold; h++) begin
        step();
        if (bus.out_valid !== 1'b1 || bus.out_int !== rev8(d)) bad++;
      end
      tests_run++;
      if (lat !== want || bus.out_sys !== d ||
          bus.out_int !== rev8(d) || il_seq_in !== d || bad !== 0) begin
        tests_failed++;
        $display("FAIL random[%0d]: d=%h lat=%0d sys=%h int=%h seq=%h bad=%0d want lat=%0d int=%h",
                 n, d, lat, bus.out_sys, bus.out_int, il_seq_in, bad, want, rev8(d));
      end
      handshake();
      seq = d;
      cache = 1'b1;
    end
    tests_run++;
    if (frame_cnt !== CW'(exp_cnt)) begin
      tests_failed++;
      $display("FAIL random_cnt: cnt=%0d want %0d", frame_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    int lat;
    drive_accept(8'h99);
    for (int i = 0; i < 8; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.out_valid, bus.out_sys, bus.out_int, il_seq_in,
         busy, frame_cnt} !== '0 || bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL async_reset: ov=%b sys=%h int=%h seq=%h busy=%b cnt=%0d rdy=%b want 0s rdy=1",
               bus.out_valid, bus.out_sys, bus.out_int, il_seq_in,
               busy, frame_cnt, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    step();
    step();
    accept_wait(8'h55, lat);
    tests_run++;
    if (lat !== L_FULL || bus.out_sys !== 8'h55 || bus.out_int !== 8'hAA) begin
      tests_failed++;
      $display("FAIL post_reset: lat=%0d sys=%h int=%h want %0d 55 aa",
               lat, bus.out_sys, bus.out_int, L_FULL);
    end
    handshake();
    tests_run++;
    if (frame_cnt !== CW'(exp_cnt)) begin
      tests_failed++;
      $display("FAIL post_reset_cnt: cnt=%0d want %0d", frame_cnt, exp_cnt);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_err_clr_race();
    test_random();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
